// File: rtl/float_pkg.sv
// rtl/float_pkg.sv - float type, sort state encoding and float helpers
package float_pkg;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exponent;
    logic [22:0] mantissa;
  } float;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    SORT  = 2'd1,
    DRAIN = 2'd2
  } fp_sort_state_e;

  // Unsigned key whose numeric order matches the float ranking:
  // positives above negatives, +0 above -0, negatives by reversed magnitude.
  function automatic logic [31:0] sort_key(float f);
    logic [31:0] bits;
    bits = f;
    return bits[31] ? ~bits : {1'b1, bits[30:0]};
  endfunction

  // Value of a finite float as a real; Inf/NaN encodings are not special-cased.
  function automatic real float_to_real(float f);
    real mag;
    if (f.exponent == 8'd0)
      mag = real'(f.mantissa) * (2.0 ** -149);
    else
      mag = (1.0 + real'(f.mantissa) / 8388608.0) * (2.0 ** (int'(f.exponent) - 127));
    return f.sign ? -mag : mag;
  endfunction

endpackage

// File: rtl/fp_sorter.sv
// rtl/fp_sorter.sv - combinational compare-exchange cell for two floats
module fp_sorter
  import float_pkg::*;
(
  input  float a,
  input  float b,
  output float bign,
  output float smalln
);

  logic a_first;

  // Keep a in front on ties so equal patterns never swap
  always_comb begin
    a_first = (sort_key(a) >= sort_key(b));
    bign    = a_first ? a : b;
    smalln  = a_first ? b : a;
  end

endmodule

// File: rtl/fp_sort_buffer.sv
// rtl/fp_sort_buffer.sv - block sorter: load N floats, odd-even transposition sort, drain descending
module fp_sort_buffer
  import float_pkg::*;
#(
  parameter int N = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_valid,
  output logic in_ready,
  input  float in_data,
  output logic out_valid,
  input  logic out_ready,
  output float out_data,
  output logic out_last,
  output logic busy
);

  localparam int IW = $clog2(N);
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  fp_sort_state_e state, state_nxt;
  logic [IW-1:0]  wr_idx, rd_idx, pass;
  float           data_buf [N];
  float           bign     [N-1];
  float           smalln   [N-1];

  // One compare-exchange cell per adjacent pair; pass parity picks which results land
  for (genvar i = 0; i < N - 1; i++) begin : g_cell
    fp_sorter u_cell (
      .a      (data_buf[i]),
      .b      (data_buf[i+1]),
      .bign   (bign[i]),
      .smalln (smalln[i])
    );
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= LOAD;
    else        state <= state_nxt;
  end

  // Next-state: fill, exactly N passes, drain to the last element
  always_comb begin
    state_nxt = state;
    case (state)
      LOAD:    if (in_valid && wr_idx == LAST)   state_nxt = SORT;
      SORT:    if (pass == LAST)                 state_nxt = DRAIN;
      DRAIN:   if (out_ready && rd_idx == LAST)  state_nxt = LOAD;
      default: state_nxt = LOAD;
    endcase
  end

  // Outputs decoded from state only, so in_ready never follows out_ready combinationally
  always_comb begin
    in_ready  = (state == LOAD);
    out_valid = (state == DRAIN);
    busy      = (state != LOAD);
    out_last  = (state == DRAIN) && (rd_idx == LAST);
    out_data  = '0;
    if (state == DRAIN) out_data = data_buf[rd_idx];
  end

  // Write, pass and read counters; each wraps to zero when its phase ends
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_idx <= '0;
      rd_idx <= '0;
      pass   <= '0;
    end else begin
      case (state)
        LOAD: begin
          pass <= '0;
          if (in_valid) wr_idx <= (wr_idx == LAST) ? '0 : wr_idx + 1'b1;
        end
        SORT: begin
          rd_idx <= '0;
          pass   <= (pass == LAST) ? '0 : pass + 1'b1;
        end
        DRAIN: begin
          if (out_ready) rd_idx <= (rd_idx == LAST) ? '0 : rd_idx + 1'b1;
        end
        default: begin
          wr_idx <= '0;
          rd_idx <= '0;
          pass   <= '0;
        end
      endcase
    end
  end

  // Block storage: loaded in LOAD, rewritten in place by the active pairs in SORT
  always_ff @(posedge clk) begin
    if (state == LOAD && in_valid) begin
      data_buf[wr_idx] <= in_data;
    end else if (state == SORT) begin
      for (int i = 0; i < N - 1; i++) begin
        if (pass[0] == 1'(i % 2)) begin
          data_buf[i]   <= bign[i];
          data_buf[i+1] <= smalln[i];
        end
      end
    end
  end

endmodule

// File: tb/tb_fp_sort_buffer.sv
// tb/tb_fp_sort_buffer.sv - randomized self-checking bench for fp_sort_buffer
module tb_fp_sort_buffer;
  import float_pkg::*;

  localparam int N = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_ready, out_valid, out_last, busy;
  logic [31:0] out_data;

  int errors = 0;
  int checks = 0;

  logic [31:0] cur_in  [N];
  logic [31:0] cur_exp [N];

  fp_sort_buffer #(.N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Ranking rule: sign first, then magnitude (reversed for negatives)
  function automatic bit ranks_above(logic [31:0] a, logic [31:0] b);
    if (a[31] != b[31]) return !a[31];
    if (!a[31]) return a[30:0] > b[30:0];
    return a[30:0] < b[30:0];
  endfunction

  // Stable descending insertion sort of cur_in into cur_exp
  task automatic build_expected();
    logic [31:0] q[$];
    q = {};
    for (int i = 0; i < N; i++) begin
      int pos = q.size();
      for (int j = 0; j < q.size(); j++) begin
        if (ranks_above(cur_in[i], q[j])) begin
          pos = j;
          break;
        end
      end
      q.insert(pos, cur_in[i]);
    end
    for (int i = 0; i < N; i++) cur_exp[i] = q[i];
  endtask

  function automatic logic [31:0] rand_float();
    logic [31:0] v;
    v[31]    = 1'($urandom_range(0, 1));
    v[30:23] = 8'($urandom_range(0, 254));
    v[22:0]  = 23'($urandom);
    return v;
  endfunction

  task automatic fill_random();
    for (int i = 0; i < N; i++) begin
      if (i > 0 && $urandom_range(0, 3) == 0) cur_in[i] = cur_in[$urandom_range(0, i - 1)];
      else                                    cur_in[i] = rand_float();
    end
  endtask

  task automatic load_block(input bit gaps, input bit hold);
    int idx = 0;
    int guard = 0;
    while (idx < N && guard < 100) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
      end else begin
        in_valid = 1'b1;
        in_data  = cur_in[idx];
      end
      if (in_valid && in_ready) idx++;
      @(posedge clk); #1;
      guard++;
    end
    if (idx < N) check_eq("load_timeout", idx, N);
    in_valid = hold;
    in_data  = 32'hDEADBEEF;
  endtask

  task automatic sort_wait();
    int cyc = 0;
    while (!out_valid && cyc < 4 * N) begin
      check_eq("sort_in_ready", in_ready, 1'b0);
      check_eq("sort_busy", busy, 1'b1);
      @(posedge clk); #1;
      cyc++;
    end
    check_eq("sort_latency", cyc, N);
  endtask

  task automatic drain_block(input bit bp);
    int idx = 0;
    int guard = 0;
    bit stalled = 1'b0;
    logic [31:0] held = '0;
    bit held_last = 1'b0;
    while (idx < N && guard < 400) begin
      if (stalled) begin
        check_eq("stall_data", out_data, held);
        check_eq("stall_last", out_last, held_last);
      end
      out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      check_eq("drain_valid", out_valid, 1'b1);
      check_eq("drain_in_ready", in_ready, 1'b0);
      check_eq($sformatf("data%0d", idx), out_data, cur_exp[idx]);
      check_eq($sformatf("last%0d", idx), out_last, (idx == N - 1));
      stalled   = !out_ready;
      held      = out_data;
      held_last = out_last;
      if (out_ready) idx++;
      @(posedge clk); #1;
      guard++;
    end
    if (idx < N) check_eq("drain_timeout", idx, N);
    check_eq("reload_in_ready", in_ready, 1'b1);
    check_eq("reload_out_valid", out_valid, 1'b0);
    check_eq("reload_busy", busy, 1'b0);
    in_valid = 1'b0;
  endtask

  task automatic run_block(input bit gaps, input bit hold, input bit bp);
    build_expected();
    load_block(gaps, hold);
    sort_wait();
    drain_block(bp);
  endtask

  task automatic pulse_reset(input string tag);
    rst_n = 1'b0;
    #1;
    check_eq({tag, "_out_valid"}, out_valid, 1'b0);
    check_eq({tag, "_in_ready"}, in_ready, 1'b1);
    check_eq({tag, "_busy"}, busy, 1'b0);
    check_eq({tag, "_out_last"}, out_last, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    in_valid = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_in_ready", in_ready, 1'b1);
    check_eq("rst_out_valid", out_valid, 1'b0);
    check_eq("rst_out_last", out_last, 1'b0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_out_data", out_data, 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Mixed-sign block: 3.5 7.2 -4.0 -5.0 3.0 0.0 100.25 -0.5
    cur_in = '{32'h40600000, 32'h40E66666, 32'hC0800000, 32'hC0A00000,
               32'h40400000, 32'h00000000, 32'h42C88000, 32'hBF000000};
    run_block(1'b0, 1'b0, 1'b0);

    // Descending, ascending, all equal
    cur_in = '{32'h41000000, 32'h40E00000, 32'h40C00000, 32'h40A00000,
               32'h40800000, 32'h40400000, 32'h40000000, 32'h3F800000};
    run_block(1'b0, 1'b0, 1'b0);
    cur_in = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
               32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000};
    run_block(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < N; i++) cur_in[i] = 32'h40000000;
    run_block(1'b0, 1'b0, 1'b0);

    // Signed zeros among small values
    cur_in = '{32'h80000000, 32'h00000000, 32'h3F800000, 32'hBF800000,
               32'h40000000, 32'hC0000000, 32'h3F000000, 32'hBF000000};
    run_block(1'b0, 1'b0, 1'b0);

    // Backpressure with in_valid held high through SORT and DRAIN
    fill_random();
    run_block(1'b1, 1'b1, 1'b1);

    // Reset during SORT, then a fresh block
    fill_random();
    build_expected();
    load_block(1'b0, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    pulse_reset("rst_sort");
    fill_random();
    run_block(1'b0, 1'b0, 1'b0);

    // Reset during DRAIN, then a fresh block
    fill_random();
    build_expected();
    load_block(1'b0, 1'b0);
    sort_wait();
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_eq("mid_drain_data", out_data, cur_exp[2]);
    pulse_reset("rst_drain");
    fill_random();
    run_block(1'b0, 1'b0, 1'b0);

    // Back-to-back gapless blocks
    fill_random();
    run_block(1'b0, 1'b0, 1'b0);
    fill_random();
    run_block(1'b0, 1'b0, 1'b0);

    // Random blocks with random gaps, holds and stalls
    for (int b = 0; b < 8; b++) begin
      fill_random();
      run_block(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
